// File: rtl/vc_flit_fifo.sv
// vc_flit_fifo
//   Virtual-channel flit FIFO for router input ports. NUM_VC independent
//   queues share one RAM; VC v owns entries {v, ptr}. Each cycle allows one
//   write and one read, each to any VC. The read data is registered, so a
//   flit appears one cycle after its rd_en.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_valid/wr_vc/wr_data   write request, target VC, flit
//   wr_ready            ~full[wr_vc] (combinational)
//   rd_en/rd_vc         read request, source VC
//   rd_data/rd_valid/rd_vc_out   registered read flit, valid, source VC
//   empty/full/almost_full       per-VC flags from the registered count
//   count               per-VC occupancy, flattened, VC0 in the LSBs
//   clear_err           clears the sticky error flags on the next edge
//   overflow_err/underflow_err   sticky write-to-full / read-from-empty

module vc_flit_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int NUM_VC       = 4,
  parameter int VC_WIDTH     = 2,
  parameter int AFULL_THRESH = 14
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_valid,
  input  logic [VC_WIDTH-1:0]                wr_vc,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  output logic                               wr_ready,
  input  logic                               rd_en,
  input  logic [VC_WIDTH-1:0]                rd_vc,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_valid,
  output logic [VC_WIDTH-1:0]                rd_vc_out,
  output logic [NUM_VC-1:0]                  empty,
  output logic [NUM_VC-1:0]                  full,
  output logic [NUM_VC-1:0]                  almost_full,
  output logic [NUM_VC*(ADDR_WIDTH+1)-1:0]   count,
  input  logic                               clear_err,
  output logic                               overflow_err,
  output logic                               underflow_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [NUM_VC*DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr [NUM_VC];
  logic [ADDR_WIDTH-1:0] rd_ptr [NUM_VC];
  logic [CNT_W-1:0]      cnt    [NUM_VC];

  logic                  wr_acc;
  logic                  rd_acc;
  logic [NUM_VC-1:0]     wr_hit;
  logic [NUM_VC-1:0]     rd_hit;

  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;
  logic [VC_WIDTH-1:0]   rd_vc_p1;

  always_comb begin
    empty       = '0;
    full        = '0;
    almost_full = '0;
    count       = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      empty[v]                 = (cnt[v] == '0);
      full[v]                  = (cnt[v] == CNT_FULL);
      almost_full[v]           = (cnt[v] >= CNT_AF);
      count[v*CNT_W +: CNT_W]  = cnt[v];
    end
  end

  // Acceptance is judged on pre-edge flags only, so a write into an empty VC
  // never satisfies a same-cycle read, and a read from a full VC never makes
  // room for a same-cycle write.
  assign wr_ready = ~full[wr_vc];
  assign wr_acc   = wr_valid & ~full[wr_vc];
  assign rd_acc   = rd_en & ~empty[rd_vc];

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_hit[v] = wr_acc && (wr_vc == VC_WIDTH'(v));
      rd_hit[v] = rd_acc && (rd_vc == VC_WIDTH'(v));
    end
  end

  // ---- stage p0 -> p1: RAM write, RAM read into the output register ----
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[{wr_vc, wr_ptr[wr_vc]}] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data_p1 <= '0;
    else if (rd_acc)
      rd_data_p1 <= mem[{rd_vc, rd_ptr[rd_vc]}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      rd_vc_p1      <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc)
        rd_vc_p1 <= rd_vc;
      // A new error event in the same cycle as clear_err keeps the flag set.
      overflow_err  <= (overflow_err  & ~clear_err) | (wr_valid & ~wr_acc);
      underflow_err <= (underflow_err & ~clear_err) | (rd_en & ~rd_acc);
      for (int v = 0; v < NUM_VC; v++) begin
        if (wr_hit[v])
          wr_ptr[v] <= wr_ptr[v] + ADDR_WIDTH'(1);
        if (rd_hit[v])
          rd_ptr[v] <= rd_ptr[v] + ADDR_WIDTH'(1);
        if (wr_hit[v] && !rd_hit[v])
          cnt[v] <= cnt[v] + CNT_W'(1);
        else if (rd_hit[v] && !wr_hit[v])
          cnt[v] <= cnt[v] - CNT_W'(1);
      end
    end
  end

  // ---- stage p1: registered read outputs ----
  assign rd_data   = rd_data_p1;
  assign rd_valid  = vld_p1;
  assign rd_vc_out = rd_vc_p1;

endmodule

// File: tb/tb_vc_flit_fifo.sv
// Testbench for vc_flit_fifo: directed steps with a reference model of the
// per-VC queues and a scoreboard of expected read results.

module tb_vc_flit_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [1:0]  wr_vc;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_en;
  logic [1:0]  rd_vc;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [1:0]  rd_vc_out;
  logic [3:0]  empty;
  logic [3:0]  full;
  logic [3:0]  almost_full;
  logic [19:0] count;
  logic        clear_err;
  logic        overflow_err;
  logic        underflow_err;

  vc_flit_fifo #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_VC(4), .VC_WIDTH(2), .AFULL_THRESH(14)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_vc(wr_vc), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_vc(rd_vc), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_vc_out(rd_vc_out), .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .clear_err(clear_err), .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: circular storage per VC plus sticky error bits.
  logic [31:0] m_data [4][16];
  int          m_wp  [4];
  int          m_rp  [4];
  int          m_cnt [4];
  bit          m_ovf;
  bit          m_udf;
  logic [33:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 4; v++) begin
      m_wp[v]  = 0;
      m_rp[v]  = 0;
      m_cnt[v] = 0;
    end
    m_ovf = 1'b0;
    m_udf = 1'b0;
    sb.delete();
  endtask

  task automatic check_state(input string tag);
    logic [3:0]  e_empty, e_full, e_af;
    logic [19:0] e_cnt;
    for (int v = 0; v < 4; v++) begin
      e_empty[v]     = (m_cnt[v] == 0);
      e_full[v]      = (m_cnt[v] == 16);
      e_af[v]        = (m_cnt[v] >= 14);
      e_cnt[v*5 +: 5] = 5'(m_cnt[v]);
    end
    chk({tag, ":empty"},       64'(empty),         64'(e_empty));
    chk({tag, ":full"},        64'(full),          64'(e_full));
    chk({tag, ":almost_full"}, 64'(almost_full),   64'(e_af));
    chk({tag, ":count"},       64'(count),         64'(e_cnt));
    chk({tag, ":overflow"},    64'(overflow_err),  64'(m_ovf));
    chk({tag, ":underflow"},   64'(underflow_err), 64'(m_udf));
  endtask

  // One clock of stimulus: drive at negedge, predict with the model using
  // pre-edge state, then check outputs 1 time unit after the posedge.
  task automatic step(input bit wv, input int wvc, input logic [31:0] wd,
                      input bit re, input int rvc, input bit clr, input string tag);
    bit          wacc, racc;
    logic [33:0] exp;
    @(negedge clk);
    wr_valid  = wv;
    wr_vc     = 2'(wvc);
    wr_data   = wd;
    rd_en     = re;
    rd_vc     = 2'(rvc);
    clear_err = clr;
    #1;
    if (wv) chk({tag, ":wr_ready"}, 64'(wr_ready), 64'(m_cnt[wvc] != 16));
    wacc = wv && (m_cnt[wvc] < 16);
    racc = re && (m_cnt[rvc] > 0);
    if (racc) begin
      sb.push_back({2'(rvc), m_data[rvc][m_rp[rvc]]});
      m_rp[rvc]  = (m_rp[rvc] + 1) % 16;
      m_cnt[rvc] = m_cnt[rvc] - 1;
    end
    if (wacc) begin
      m_data[wvc][m_wp[wvc]] = wd;
      m_wp[wvc]  = (m_wp[wvc] + 1) % 16;
      m_cnt[wvc] = m_cnt[wvc] + 1;
    end
    m_ovf = (m_ovf & ~clr) | (wv & ~wacc);
    m_udf = (m_udf & ~clr) | (re & ~racc);
    @(posedge clk);
    #1;
    wr_valid  = 1'b0;
    rd_en     = 1'b0;
    clear_err = 1'b0;
    chk({tag, ":rd_valid"}, 64'(rd_valid), 64'(racc));
    if (racc && sb.size() > 0) begin
      exp = sb.pop_front();
      chk({tag, ":rd_data"},   64'(rd_data),   64'(exp[31:0]));
      chk({tag, ":rd_vc_out"}, 64'(rd_vc_out), 64'(exp[33:32]));
    end
    check_state(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_vc     = '0;
    wr_data   = '0;
    rd_en     = 1'b0;
    rd_vc     = '0;
    clear_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    for (int v = 0; v < 4; v++) begin
      wr_vc = 2'(v);
      #1;
      chk("reset:wr_ready", 64'(wr_ready), 64'(1));
    end
    chk("reset:rd_valid", 64'(rd_valid), 64'(0));
    chk("reset:rd_data",  64'(rd_data),  64'(0));
    check_state("reset");

    // Fill VC2 to full, overflow on the 17th, then drain in order
    for (int i = 0; i < 16; i++) step(1, 2, 32'h100 + 32'(i), 0, 0, 0, "vc2_fill");
    step(1, 2, 32'h110, 0, 0, 0, "vc2_overflow");
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 2, 0, "vc2_drain");

    // Interleaved VC0 / VC3 traffic
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 32'hA0 + 32'(i), 0, 0, 0, "vc0_wr");
      step(1, 3, 32'hB0 + 32'(i), 0, 0, 0, "vc3_wr");
    end
    step(1, 0, 32'hA6, 1, 3, 0, "vc0_wr_vc3_rd");
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1, 3, 0, "vc3_rd");
      step(0, 0, 0, 1, 0, 0, "vc0_rd");
    end
    step(0, 0, 0, 1, 0, 0, "vc0_rd_last");

    // VC1 streaming at depth 1 with simultaneous write and read, wrapping pointers
    step(1, 1, 32'hC00, 0, 0, 0, "vc1_prime");
    for (int i = 0; i < 20; i++) step(1, 1, 32'hC01 + 32'(i), 1, 1, 0, "vc1_stream");
    step(0, 0, 0, 1, 1, 0, "vc1_drain");

    // Write + read to empty VC0 in the same cycle: read rejected
    step(1, 0, 32'h55, 1, 0, 0, "vc0_wr_rd_empty");
    step(0, 0, 0, 0, 0, 1, "clear_err");
    // Error event in the same cycle as clear_err keeps the flag
    step(0, 0, 0, 1, 2, 1, "clear_vs_set");
    step(0, 0, 0, 0, 0, 1, "clear_err2");
    step(0, 0, 0, 1, 0, 0, "vc0_rd_55");

    // Full VC3 with a same-cycle write and read: read wins, write dropped
    for (int i = 0; i < 16; i++) step(1, 3, 32'hE0 + 32'(i), 0, 0, 0, "vc3_fill");
    step(1, 3, 32'hEF0, 1, 3, 0, "vc3_full_wr_rd");

    // Asynchronous reset mid-stream with VC1 holding entries
    for (int i = 0; i < 9; i++) step(1, 1, 32'hD0 + 32'(i), 0, 0, 0, "rst_fill");
    step(0, 0, 0, 1, 1, 0, "rst_pre_rd");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst:rd_valid",  64'(rd_valid),  64'(0));
    chk("async_rst:rd_data",   64'(rd_data),   64'(0));
    chk("async_rst:rd_vc_out", 64'(rd_vc_out), 64'(0));
    check_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 1, 1, 0, "post_rst_rd");
    step(1, 1, 32'hF1, 0, 0, 0, "post_rst_wr");
    step(0, 0, 0, 1, 1, 0, "post_rst_rd2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
